// File: rtl/gsram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gsram_port_arbiter_pkg
// Shared types and constants for the global SRAM port arbiter.
//   GSRAM_ADDR_W  : global SRAM address width (depth 1024)
//   GSRAM_LEN_W   : burst length field width (beats-1, 1..64 beats)
//   arb_state_e   : arbiter FSM state
//   gsram_burst_t : one burst descriptor {wr, addr, len} as seen by requesters
// -----------------------------------------------------------------------------
package gsram_port_arbiter_pkg;

    localparam int GSRAM_ADDR_W = 10;
    localparam int GSRAM_LEN_W  = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                    wr;
        logic [GSRAM_ADDR_W-1:0] addr;
        logic [GSRAM_LEN_W-1:0]  len;
    } gsram_burst_t;

endpackage

// File: rtl/gsram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// gsram_port_arbiter_if
// Bundles the requester side and the SRAM side of the arbiter.
//   req/req_wr/req_addr/req_len : per-requester burst requests (flattened)
//   gnt/beat_ack                : one-hot grant pulse and per-beat acknowledge
//   busy                        : burst in progress
//   global_sram_*               : address/enable/owner-select to the SRAM macro
//   rvalid/rlast                : one-hot read-data valid and last qualifier
// Modports: slave = the arbiter, master = the requesters/SRAM environment.
// -----------------------------------------------------------------------------
interface gsram_port_arbiter_if
    import gsram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = GSRAM_ADDR_W,
    parameter int LEN_W   = GSRAM_LEN_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        beat_ack;
    logic                      busy;
    logic [ADDR_W-1:0]         global_sram_waddr;
    logic [ADDR_W-1:0]         global_sram_raddr;
    logic                      global_sram_wen;
    logic                      global_sram_ren;
    logic [ID_W-1:0]           global_sram_sel;
    logic [NUM_REQ-1:0]        rvalid;
    logic [NUM_REQ-1:0]        rlast;

    modport slave (
        input  req, req_wr, req_addr, req_len,
        output gnt, beat_ack, busy,
        output global_sram_waddr, global_sram_raddr,
        output global_sram_wen, global_sram_ren, global_sram_sel,
        output rvalid, rlast
    );

    modport master (
        output req, req_wr, req_addr, req_len,
        input  gnt, beat_ack, busy,
        input  global_sram_waddr, global_sram_raddr,
        input  global_sram_wen, global_sram_ren, global_sram_sel,
        input  rvalid, rlast
    );

endinterface

// File: rtl/gsram_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// gsram_rr_pick
// Combinational round-robin picker: selects the first active request at or
// after i_ptr, wrapping around.
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_valid  : at least one request active
//   o_id     : selected index
//   o_onehot : selected index, one-hot (all zero when !o_valid)
// -----------------------------------------------------------------------------
module gsram_rr_pick
    import gsram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id,
    output logic [NUM_REQ-1:0] o_onehot
);

    // w_cand[k] is the requester index holding priority rank k this round
    logic [ID_W-1:0] w_cand [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_cand[gi] = ID_W'((int'(i_ptr) + gi) % NUM_REQ);
    end

    always_comb begin
        o_valid  = 1'b0;
        o_id     = '0;
        // Walk from lowest priority to highest so the highest rank wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_valid = 1'b1;
                o_id    = w_cand[k];
            end
        end
        o_onehot = o_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_id) : '0;
    end

endmodule

// File: rtl/gsram_port_arbiter.sv
// -----------------------------------------------------------------------------
// gsram_port_arbiter
// Shares the single global SRAM port between NUM_REQ burst requesters
// (index NUM_REQ-1 is the host loader). Round-robin grant per burst, one beat
// per cycle with incrementing address, read-valid routed back RD_LAT cycles
// after each ren.
//   clk  : clock
//   rstn : asynchronous reset, active low
//   bus  : gsram_port_arbiter_if slave modport (requests in; grant, beat,
//          SRAM address/enables/select and read-return out)
// -----------------------------------------------------------------------------
module gsram_port_arbiter
    import gsram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = GSRAM_ADDR_W,
    parameter int LEN_W   = GSRAM_LEN_W,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    gsram_port_arbiter_if.slave   bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_beat_ack;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_raddr;
    logic                r_wen;
    logic                r_ren;
    logic                r_last;
    logic [ID_W-1:0]     r_sel;

    // Read-return pipeline: stage RD_LAT-1 is presented on rvalid/rlast
    logic                r_pv  [RD_LAT];
    logic [ID_W-1:0]     r_pid [RD_LAT];
    logic                r_pl  [RD_LAT];

    logic                w_pick_valid;
    logic [ID_W-1:0]     w_pick_id;
    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [ADDR_W-1:0]   w_req_addr [NUM_REQ];
    logic [LEN_W-1:0]    w_req_len  [NUM_REQ];
    logic [NUM_REQ-1:0]  w_rvalid;
    logic [NUM_REQ-1:0]  w_rlast;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign w_req_len[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
    end

    gsram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_id     (w_pick_id),
        .o_onehot (w_pick_onehot)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_beat_ack <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_wen      <= 1'b0;
            r_ren      <= 1'b0;
            r_last     <= 1'b0;
            r_sel      <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    // Grant cycle never carries a beat: this is the bubble
                    r_wen      <= 1'b0;
                    r_ren      <= 1'b0;
                    r_beat_ack <= '0;
                    r_last     <= 1'b0;
                    if (w_pick_valid) begin
                        r_gnt    <= w_pick_onehot;
                        r_id     <= w_pick_id;
                        r_wr     <= bus.req_wr[w_pick_id];
                        r_addr   <= w_req_addr[w_pick_id];
                        r_cnt    <= w_req_len[w_pick_id];
                        r_rr_ptr <= (w_pick_id == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_id + 1'b1;
                        r_state  <= BURST;
                    end
                end
                BURST: begin
                    r_wen <= r_wr;
                    r_ren <= !r_wr;
                    // The idle direction's address holds its last value
                    if (r_wr) begin
                        r_waddr <= r_addr;
                    end else begin
                        r_raddr <= r_addr;
                    end
                    r_beat_ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_id;
                    r_sel      <= r_id;
                    r_last     <= (r_cnt == '0);
                    r_addr     <= r_addr + 1'b1;
                    r_cnt      <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rpipe
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_pv[gi]  <= 1'b0;
                r_pid[gi] <= '0;
                r_pl[gi]  <= 1'b0;
            end else if (gi == 0) begin
                r_pv[gi]  <= r_ren;
                r_pid[gi] <= r_sel;
                r_pl[gi]  <= r_ren && r_last;
            end else begin
                r_pv[gi]  <= r_pv[gi-1];
                r_pid[gi] <= r_pid[gi-1];
                r_pl[gi]  <= r_pl[gi-1];
            end
        end
    end

    always_comb begin
        w_rvalid = '0;
        w_rlast  = '0;
        if (r_pv[RD_LAT-1]) begin
            w_rvalid[r_pid[RD_LAT-1]] = 1'b1;
            w_rlast[r_pid[RD_LAT-1]]  = r_pl[RD_LAT-1];
        end
    end

    assign bus.gnt               = r_gnt;
    assign bus.beat_ack          = r_beat_ack;
    assign bus.busy              = (r_state == BURST);
    assign bus.global_sram_waddr = r_waddr;
    assign bus.global_sram_raddr = r_raddr;
    assign bus.global_sram_wen   = r_wen;
    assign bus.global_sram_ren   = r_ren;
    assign bus.global_sram_sel   = r_sel;
    assign bus.rvalid            = w_rvalid;
    assign bus.rlast             = w_rlast;

endmodule
